// File: rtl/trace_packet_arbiter.sv
// trace_packet_arbiter: weighted round-robin packet arbiter with a one-beat registered output buffer.
module trace_packet_arbiter #(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_sop,
    input  logic [NUM_IN-1:0]        in_eop,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic [1:0]               out_channel,
    input  logic [NUM_IN-1:0]        cfg_enable,
    input  logic [4*NUM_IN-1:0]      cfg_weight,
    output logic [1:0]               grant_id,
    output logic                     busy
);
    typedef enum logic {ARB, XFER} state_t;
    state_t state;
    logic [1:0] last, win;
    logic [3:0] credit, weight;
    logic [NUM_IN-1:0] elig;
    logic found, regrant, accept;

    assign elig     = in_valid & cfg_enable;
    assign regrant  = credit != 4'd0 && elig[grant_id];
    assign weight   = cfg_weight[4*win +: 4];
    assign in_ready = (state == XFER && (out_ready || !out_valid)) ? NUM_IN'(1) << grant_id : '0;
    assign accept   = in_valid[grant_id] && in_ready[grant_id];

    // Scan downward so the nearest eligible requester after the last grant wins.
    always_comb begin
        found = 1'b0;
        win   = last;
        for (int i = NUM_IN; i >= 1; i--) begin
            if (elig[last + 2'(i)]) begin
                found = 1'b1;
                win   = last + 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ARB;
            grant_id    <= 2'd0;
            last        <= 2'd3;
            credit      <= 4'd0;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            out_channel <= 2'd0;
        end else begin
            if (accept) begin
                out_valid   <= 1'b1;
                out_data    <= in_data[DATA_W*grant_id +: DATA_W];
                out_sop     <= in_sop[grant_id];
                out_eop     <= in_eop[grant_id];
                out_channel <= grant_id;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (state == ARB) begin
                if (regrant || found) begin
                    state <= XFER;
                    busy  <= 1'b1;
                end
                if (!regrant && found) begin
                    grant_id <= win;
                    last     <= win;
                    credit   <= (weight == 4'd0) ? 4'd1 : weight;
                end
            end else if (accept && in_eop[grant_id]) begin
                state  <= ARB;
                busy   <= 1'b0;
                credit <= (credit == 4'd0) ? 4'd0 : credit - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_trace_packet_arbiter.sv
// tb_trace_packet_arbiter: directed packet streams with a scoreboard of expected output beats.
module tb_trace_packet_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  in_valid, in_ready, in_sop, in_eop, cfg_enable;
    logic [31:0] in_data;
    logic [15:0] cfg_weight;
    logic        out_valid, out_ready, out_sop, out_eop, busy;
    logic [7:0]  out_data;
    logic [1:0]  out_channel, grant_id;

    logic [9:0]  src_q [4][$];
    logic [11:0] sb_q [$];
    int checks = 0, errors = 0, popped = 0;

    always #5 clk = ~clk;

    trace_packet_arbiter #(.NUM_IN(4), .DATA_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .out_channel(out_channel), .cfg_enable(cfg_enable), .cfg_weight(cfg_weight),
        .grant_id(grant_id), .busy(busy)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void drive();
        for (int i = 0; i < 4; i++) begin
            in_valid[i] = src_q[i].size() != 0;
            {in_sop[i], in_eop[i], in_data[8*i +: 8]} = in_valid[i] ? src_q[i][0] : 10'h0;
        end
    endfunction

    // Beats of a packet go to the requester's source; expected beats go to the scoreboard in call order.
    task automatic add_pkt(int ch, int len, logic [7:0] base, bit exp);
        for (int b = 0; b < len; b++) begin
            logic [9:0] beat;
            beat = {b == 0, b == len - 1, base + 8'(b)};
            src_q[ch].push_back(beat);
            if (exp) sb_q.push_back({2'(ch), beat});
        end
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) src_q[i].delete();
        sb_q.delete();
        drive();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        flush();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_drain(string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check(name, sb_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_pop(int target, string name);
        int n = 0;
        while (popped < target && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check(name, popped >= target, 1);
    endtask

    initial begin
        logic [3:0] fire;
        forever begin
            @(negedge clk);
            fire = in_valid & in_ready;
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++)
                if (fire[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
            drive();
        end
    end

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got ch %0d data %0h with nothing expected", out_channel, out_data);
            end else begin
                check("beat", {out_channel, out_sop, out_eop, out_data}, sb_q[0]);
                void'(sb_q.pop_front());
                popped++;
            end
        end
    end

    initial begin
        out_ready = 1'b1; cfg_enable = 4'hF; cfg_weight = 16'h1110;
        in_valid = '0; in_data = '0; in_sop = '0; in_eop = '0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_out_payload", {out_channel, out_sop, out_eop, out_data}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Plain round robin, 2-beat packets, requester 0 weight 0 acting as 1.
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 4; c++) add_pkt(c, 2, 8'(c*64 + p*8), 1'b1);
        drive();
        wait_drain("rr_order");
        check("rr_idle_busy", busy, 0);

        // Weighted: requester 1 quota 3, requester 2 quota 0 (treated as 1).
        do_reset();
        cfg_weight = 16'h0030;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) add_pkt(1, 1, 8'(16 + k*4 + j), 1'b1);
            add_pkt(2, 1, 8'(32 + k), 1'b1);
        end
        drive();
        wait_drain("weighted");

        // Output stall for 5 cycles mid-packet.
        do_reset();
        cfg_weight = 16'h1111;
        add_pkt(0, 4, 8'h40, 1'b1);
        drive();
        wait_pop(popped + 2, "stall_start");
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_payload", {out_channel, out_sop, out_eop, out_data}, sb_q[0]);
            check("stall_in_ready", in_ready, 0);
            check("stall_busy", busy, 1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_drain("stall_release");

        // Disable requester 0 mid-packet: packet completes, no re-grant despite remaining quota.
        do_reset();
        cfg_weight = 16'h1112;
        add_pkt(0, 4, 8'h50, 1'b1);
        add_pkt(0, 4, 8'h58, 1'b0);
        add_pkt(1, 2, 8'h60, 1'b1);
        drive();
        wait_pop(popped + 2, "disable_start");
        @(posedge clk); #1 cfg_enable = 4'hE;
        wait_drain("disable_order");
        check("disable_busy", busy, 0);
        check("disable_in_ready", in_ready, 0);
        check("disable_pending", src_q[0].size(), 4);
        do_reset();
        cfg_enable = 4'hF;

        // Asynchronous reset during beat 3 of a 6-beat packet.
        add_pkt(0, 6, 8'h70, 1'b1);
        drive();
        wait_pop(popped + 2, "midreset_start");
        @(posedge clk); #2 reset_n = 1'b0;
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_busy", busy, 0);
        check("midreset_in_ready", in_ready, 0);
        check("midreset_grant_id", grant_id, 0);
        flush();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_idle", out_valid, 0);
        add_pkt(0, 1, 8'h80, 1'b1);
        add_pkt(1, 1, 8'h90, 1'b1);
        drive();
        wait_drain("midreset_regrant");

        // Only a disabled requester is valid: nothing moves.
        do_reset();
        cfg_enable = 4'h7;
        add_pkt(3, 1, 8'hA0, 1'b0);
        drive();
        repeat (10) begin
            @(negedge clk);
            check("disabled_in_ready", in_ready, 0);
            check("disabled_out_valid", out_valid, 0);
            check("disabled_busy", busy, 0);
        end
        do_reset();
        cfg_enable = 4'hF;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/trace_packet_arbiter.md
TRACE_PACKET_ARBITER -- requirements
Module: trace_packet_arbiter

Interface
REQ-001 The block SHALL have parameters: NUM_IN, default 4, number of requesters (fixed 4 in this revision); DATA_W, default 8, data width per beat.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  4  per-requester Avalon-ST valid; bit i = requester i.
REQ-005 in_ready  out  4  per-requester ready.
REQ-006 in_data  in  32  requester i data in bits [8i+7:8i].
REQ-007 in_sop, in_eop  in  4 each  per-requester start/end of packet.
REQ-008 out_valid  out  1, out_ready  in  1, out_data  out  8, out_sop  out  1, out_eop  out  1: arbitrated Avalon-ST source.
REQ-009 out_channel  out  2  index of requester that produced the current out beat.
REQ-010 cfg_enable  in  4  per-requester enable mask; disabled requesters are never newly granted.
REQ-011 cfg_weight  in  16  4-bit packet quota per requester, bits [4i+3:4i]; value 0 treated as 1.
REQ-012 grant_id  out  2, busy  out  1: current grant and "packet in progress" status.

Function
REQ-013 FSM states SHALL be ARB and XFER; reset state ARB.
REQ-014 In ARB, if the current grant has credit > 0, is enabled and its in_valid is high, it SHALL be re-granted without rotation.
REQ-015 Otherwise in ARB the winner SHALL be the first enabled requester with in_valid high, searching round-robin from (last grant + 1) mod 4; credit reloads to its cfg_weight (0 -> 1).
REQ-016 With no eligible requester, ARB SHALL remain in ARB, all in_ready low, grant_id unchanged.
REQ-017 A grant decided in ARB SHALL register grant_id and enter XFER on the next edge; busy high throughout XFER.
REQ-018 In XFER, in_ready[grant_id] SHALL equal (out_ready OR NOT out_valid); all other in_ready bits SHALL be 0 (non-granted requesters are back-pressured, never dropped).
REQ-019 Output stage SHALL be a single registered buffer: an accepted input beat appears on out_* with out_channel = grant_id one cycle later (latency 1).
REQ-020 out_valid SHALL set on an accepted beat, clear when out_ready is high with no new accepted beat, and hold with payload stable while out_ready is low.
REQ-021 Accepting a beat with in_eop high SHALL decrement credit (saturating at 0), and return to ARB on the next edge; one bubble cycle per packet boundary is permitted.
REQ-022 Single-beat packets (sop and eop together) SHALL complete XFER in one accepted beat.
REQ-023 Beats SHALL pass unmodified; missing in_sop on the first beat is not checked or corrected.
REQ-024 Clearing cfg_enable for the granted requester mid-packet SHALL NOT abort the packet; it takes effect at next ARB.
REQ-025 cfg_weight changes SHALL take effect only at the next credit reload.
REQ-026 Packet interleaving between requesters SHALL never occur on out_*.

Reset
REQ-027 On reset_n low, asynchronously: state ARB, grant_id 0, last-grant pointer 3 (so requester 0 wins first), credit 0, busy 0, out_valid 0, out_data/out_sop/out_eop/out_channel 0, in_ready 0.
REQ-028 Reset mid-packet SHALL discard the partial packet and output buffer; no beat emitted after deassertion until a new grant.

Verification
REQ-029 Reset then all four valid, enable 4'hF, weights 1, 2-beat packets, out_ready=1 -> out_channel sequence 0,0,1,1,2,2,3,3,0,...; sop/eop intact.
REQ-030 Requester 1 weight 3, requester 2 weight 1, both always valid, single-beat packets -> channels 1,1,1,2,1,1,1,2,...
REQ-031 out_ready held low 5 cycles mid-packet -> out_* stable, in_ready[grant]=0, no beat lost or duplicated after release.
REQ-032 Requester 0 granted, cfg_enable[0] cleared after beat 2 of 4 -> all 4 beats delivered, then requester 0 not re-granted.
REQ-033 reset_n pulsed low during beat 3 of a 6-beat packet -> out_valid 0 immediately; next grant goes to requester 0 if valid.
REQ-034 Only requester 3 valid, enable 4'h7 -> in_ready stays 0, out_valid stays 0, busy stays 0.
